// File: rtl/pulse_timer_bank.sv
// Bank of independent pulse timers: each channel counts its programmed period and
// emits a one-cycle flag at terminal count, either periodically or once.
//
// state  | meaning
// IDLE   | stopped, counter held at 0, waits for ch_en
// RUN    | counting, flag on terminal count
// DONE   | one-shot finished, waits for ch_en low before re-arm
module pulse_timer_bank #(
  parameter int          N_CH       = 4,
  parameter int          CNT_W      = 32,
  parameter int unsigned DEF_PERIOD = 50000000
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  ch_en,
  input  logic [N_CH-1:0]  ch_clr,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic             cfg_oneshot,
  output logic [N_CH-1:0]  flag,
  output logic [N_CH-1:0]  busy,
  output logic             cfg_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic cfg_ok;
  assign cfg_ok = (cfg_period != '0) && ({1'b0, cfg_sel} < 5'(N_CH));

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) cfg_err <= 1'b0;
    else     cfg_err <= cfg_we && !cfg_ok;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic             oneshot;
    logic             flag_r;
    logic             wr_hit;
    logic             tc;

    assign wr_hit  = cfg_we && cfg_ok && (cfg_sel == 4'(i));
    assign tc      = (cnt == period - 1'b1);
    assign flag[i] = flag_r;
    assign busy[i] = (state == S_RUN);

    always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
        state   <= S_IDLE;
        cnt     <= '0;
        period  <= CNT_W'(DEF_PERIOD);
        oneshot <= 1'b0;
        flag_r  <= 1'b0;
      end else begin
        flag_r <= 1'b0;
        if (wr_hit) begin
          period  <= cfg_period;
          oneshot <= cfg_oneshot;
        end
        // clear beats a write, which beats the normal count; a write still stores its config
        if (ch_clr[i]) begin
          state <= S_IDLE;
          cnt   <= '0;
        end else if (wr_hit) begin
          cnt <= '0;
        end else begin
          case (state)
            S_IDLE: begin
              cnt <= '0;
              if (ch_en[i]) state <= S_RUN;
            end
            S_RUN: begin
              if (!ch_en[i]) begin
                state <= S_IDLE;
                cnt   <= '0;
              end else if (tc) begin
                cnt    <= '0;
                flag_r <= 1'b1;
                if (oneshot) state <= S_DONE;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            S_DONE: begin
              cnt <= '0;
              if (!ch_en[i]) state <= S_IDLE;
            end
            default: begin
              state <= S_IDLE;
              cnt   <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_timer_bank.sv
// Scoreboard bench for pulse_timer_bank: expected flag/cfg_err events are queued by
// the stimulus and matched by an independent monitor sampling on the falling edge.
`timescale 1ns/1ps
module tb_pulse_timer_bank;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;

  typedef struct {
    int         at_edge;
    logic [3:0] flag;
    logic       err;
  } exp_t;

  logic             sys_clk = 1'b0;
  logic             rst = 1'b1;
  logic [N_CH-1:0]  ch_en = '0;
  logic [N_CH-1:0]  ch_clr = '0;
  logic             cfg_we = 1'b0;
  logic [3:0]       cfg_sel = '0;
  logic [CNT_W-1:0] cfg_period = '0;
  logic             cfg_oneshot = 1'b0;
  logic [N_CH-1:0]  flag;
  logic [N_CH-1:0]  busy;
  logic             cfg_err;

  exp_t exp_q[$];
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  int   e;

  pulse_timer_bank #(.N_CH(N_CH), .CNT_W(CNT_W), .DEF_PERIOD(5)) dut (
    .sys_clk(sys_clk), .rst(rst), .ch_en(ch_en), .ch_clr(ch_clr),
    .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_period(cfg_period),
    .cfg_oneshot(cfg_oneshot), .flag(flag), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) edge_n++;

  // monitor: every nonzero flag/cfg_err cycle must match the next queued event
  always @(negedge sys_clk) begin
    if (!rst && (flag != '0 || cfg_err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event edge=%0d flag=%b err=%b (none expected)", edge_n, flag, cfg_err);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        if (x.at_edge != edge_n || x.flag != flag || x.err != cfg_err) begin
          errors++;
          $display("FAIL event edge=%0d flag=%b err=%b, expected edge=%0d flag=%b err=%b",
                   edge_n, flag, cfg_err, x.at_edge, x.flag, x.err);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic push(input int at, input logic [3:0] f, input logic er);
    exp_t x;
    x.at_edge = at; x.flag = f; x.err = er;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, expv);
    end
  endtask

  task automatic cfg_write(input logic [3:0] sel, input logic [CNT_W-1:0] per, input logic os);
    cfg_we = 1'b1; cfg_sel = sel; cfg_period = per; cfg_oneshot = os;
    tick(1);
    cfg_we = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at edge=%0d", edge_n);
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    chk("reset_flag", 32'(flag), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_err", 32'(cfg_err), 0);
    rst = 1'b0;
    tick(2);

    // ch0 periodic at default period 5
    e = edge_n; ch_en = 4'b0001;
    push(e + 6, 4'b0001, 0); push(e + 11, 4'b0001, 0); push(e + 16, 4'b0001, 0);
    tick(2);
    chk("busy_ch0_run", 32'(busy), 32'b0001);
    tick(14);
    ch_en = 4'b0000;
    tick(2);
    chk("busy_ch0_stop", 32'(busy), 0);

    // ch1 one-shot period 3, then re-arm through IDLE
    cfg_write(4'd1, 16'd3, 1'b1);
    e = edge_n; ch_en = 4'b0010; push(e + 4, 4'b0010, 0);
    tick(2);
    chk("busy_ch1_run", 32'(busy), 32'b0010);
    tick(3);
    chk("busy_ch1_done", 32'(busy), 0);
    ch_en = 4'b0000;
    tick(2);
    e = edge_n; ch_en = 4'b0010; push(e + 4, 4'b0010, 0);
    tick(6);
    chk("busy_ch1_done2", 32'(busy), 0);
    ch_en = 4'b0000;
    tick(2);

    // ch2 period 1: flag held high, clear drops it next cycle
    cfg_write(4'd2, 16'd1, 1'b0);
    e = edge_n; ch_en = 4'b0100;
    for (int k = 2; k <= 6; k++) push(e + k, 4'b0100, 0);
    tick(6);
    chk("busy_ch2_run", 32'(busy), 32'b0100);
    ch_clr = 4'b0100; ch_en = 4'b0000;
    tick(1);
    ch_clr = 4'b0000;
    chk("busy_ch2_clr", 32'(busy), 0);
    chk("flag_ch2_clr", 32'(flag), 0);
    tick(2);

    // rejected writes
    push(edge_n + 1, 4'b0000, 1);
    cfg_write(4'd5, 16'd3, 1'b0);
    push(edge_n + 1, 4'b0000, 1);
    cfg_write(4'd0, 16'd0, 1'b0);
    tick(2);

    // ch0 still at 5; a write at terminal count suppresses the flag and reloads 7
    e = edge_n; ch_en = 4'b0001;
    push(e + 6, 4'b0001, 0); push(e + 11, 4'b0001, 0);
    push(e + 23, 4'b0001, 0); push(e + 30, 4'b0001, 0);
    tick(15);
    cfg_write(4'd0, 16'd7, 1'b0);
    tick(15);
    ch_en = 4'b0000;
    tick(2);

    // clear and write to ch3 together: new period stored, channel idled
    ch_en = 4'b1000;
    tick(3);
    ch_clr = 4'b1000; ch_en = 4'b0000;
    cfg_write(4'd3, 16'd2, 1'b0);
    ch_clr = 4'b0000;
    chk("busy_ch3_clrwr", 32'(busy), 0);
    e = edge_n; ch_en = 4'b1000;
    push(e + 3, 4'b1000, 0); push(e + 5, 4'b1000, 0);
    tick(5);
    ch_en = 4'b0000;
    tick(2);

    // asynchronous reset mid-count, then default period restored on ch0
    e = edge_n; ch_en = 4'b0001;
    tick(4);
    chk("busy_before_rst", 32'(busy), 32'b0001);
    rst = 1'b1;
    #1;
    chk("rst_async_busy", 32'(busy), 0);
    chk("rst_async_flag", 32'(flag), 0);
    chk("rst_async_err", 32'(cfg_err), 0);
    ch_en = 4'b0000;
    tick(2);
    rst = 1'b0;
    tick(1);
    e = edge_n; ch_en = 4'b0001;
    push(e + 6, 4'b0001, 0);
    tick(8);
    ch_en = 4'b0000;
    tick(3);

    chk("pending_events", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pulse_timer_bank.md
PULSE_TIMER_BANK -- requirements
Module: pulse_timer_bank

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent pulse channels (1..16).
REQ-002 SHALL have parameter CNT_W, default 32: counter and period width in bits.
REQ-003 SHALL have parameter DEF_PERIOD, default 50000000: reset period of every channel, in cycles (1 s at 50 MHz).
REQ-004 SHALL have port sys_clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port ch_en, input, N_CH: per-channel run enable, level-sensitive.
REQ-007 SHALL have port ch_clr, input, N_CH: per-channel synchronous clear, active-high.
REQ-008 SHALL have port cfg_we, input, 1: configuration write strobe, one cycle per write.
REQ-009 SHALL have port cfg_sel, input, 4: target channel index of the write.
REQ-010 SHALL have port cfg_period, input, CNT_W: new period in cycles.
REQ-011 SHALL have port cfg_oneshot, input, 1: new mode (1 = one-shot, 0 = periodic).
REQ-012 SHALL have port flag, output, N_CH: registered one-cycle tick per channel.
REQ-013 SHALL have port busy, output, N_CH: 1 while the channel is in RUN.
REQ-014 SHALL have port cfg_err, output, 1: registered one-cycle pulse on a rejected write.

Function
REQ-015 Each channel SHALL hold period[CNT_W], oneshot, counter[CNT_W], state in {IDLE, RUN, DONE}, all independent of other channels.
REQ-016 IDLE: counter = 0, busy = 0; ch_en = 1 sampled -> RUN with counter = 0.
REQ-017 RUN: counter += 1 per cycle; at counter == period-1 -> counter = 0, flag = 1 in the next cycle, and state stays RUN if oneshot = 0 or goes to DONE if oneshot = 1.
REQ-018 Timing: ch_en first sampled high at edge 0 -> flag high for exactly the cycle after edge P (P = period), then after edges 2P, 3P, ... in periodic mode.
REQ-019 period = 1 in periodic mode SHALL hold flag continuously high while RUN.
REQ-020 RUN with ch_en = 0 sampled -> IDLE, counter = 0, no flag, even if counter == period-1 that cycle.
REQ-021 DONE: busy = 0, counter = 0, no flags; ch_en = 0 sampled -> IDLE; re-arm only via IDLE.
REQ-022 flag SHALL be 0 in every cycle not following a terminal count; never two cycles wide except when period = 1.
REQ-023 A valid write (cfg_we = 1, cfg_sel < N_CH, cfg_period != 0) SHALL load period and oneshot of channel cfg_sel and force its counter to 0 without changing state.
REQ-024 A write coinciding with the terminal count of the same channel SHALL win: no flag, counter = 0, state unchanged.
REQ-025 A write with cfg_sel >= N_CH or cfg_period = 0 SHALL change nothing and pulse cfg_err high for one cycle.
REQ-026 ch_clr[i] = 1 SHALL force channel i to IDLE, counter = 0, flag[i] = 0 next cycle, keeping period and oneshot; it overrides ch_en and terminal count.
REQ-027 ch_clr and a valid write to the same channel in one cycle SHALL both take effect: new period/mode stored, channel cleared to IDLE.
REQ-028 Counter SHALL never exceed period-1; no wrap through 2^CNT_W is reachable.

Reset
REQ-029 rst = 1 SHALL immediately, without a clock, force every counter = 0, state = IDLE, flag = 0, busy = 0, cfg_err = 0, period = DEF_PERIOD, oneshot = 0.
REQ-030 After rst falls, channels SHALL start only on a sampled ch_en = 1; reset asserted mid-count SHALL discard the count with no flag emitted.

Verification (DEF_PERIOD = 5, N_CH = 4)
REQ-031 ch_en = 4'b0001 held from edge 0 -> flag[0] high after edges 5, 10, 15; other flags 0; busy[0] = 1.
REQ-032 write ch 1 period 3 oneshot 1, then ch_en[1] = 1 -> flag[1] once after 3 edges, busy[1] falls to 0 (DONE); toggling ch_en[1] low then high re-fires once.
REQ-033 write ch 2 period 1 periodic, ch_en[2] = 1 -> flag[2] continuously high; ch_clr[2] pulse -> flag[2] = 0 next cycle, busy[2] = 0.
REQ-034 write cfg_sel = 5 or cfg_period = 0 -> cfg_err pulses one cycle, all periods and counters unchanged.
REQ-035 ch 0 running, write ch 0 period 7 at counter = 4 (terminal) -> no flag that cycle, next flag 7 cycles later.
REQ-036 rst asserted asynchronously mid-count at counter = 3 -> all outputs 0 before the next edge; after release, flag only DEF_PERIOD cycles after ch_en is sampled.
